// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, data port and memory port of mem_arbiter.
// Ports: fetch (if_*), data (d_*), memory (m_*); slave = arbiter side, master = environment side.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_ready, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rvalid, m_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ready, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port, one transaction in flight.
// Ports: clk, reset (async, active-high), bus (mem_arbiter_if.slave), busy, grant_id (0=fetch, 1=data).
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus,
    output logic           busy,
    output logic           grant_id
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic [3:0] starve_q, starve_d;
    cmd_t       cmd_q, cmd_d;
    logic       fetch_win;

    // Data has priority; fetch only overtakes once it has been passed over
    // STARVE_MAX times in a row (or when data is not asking at all).
    assign fetch_win = bus.if_req && (!bus.d_req || starve_q == SMAX);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        starve_d      = starve_q;
        cmd_d         = cmd_q;
        bus.if_ready  = 1'b0;
        bus.d_ready   = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.m_req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_d = ISSUE;
                    grant_d = !fetch_win;
                    if (fetch_win) begin
                        bus.if_ready = 1'b1;
                        starve_d     = 4'd0;
                        cmd_d        = '{we: 1'b0, addr: bus.if_addr,
                                         wdata: 32'd0, wstrb: 4'd0};
                    end else begin
                        bus.d_ready = 1'b1;
                        if (!bus.if_req)
                            starve_d = 4'd0;
                        else if (starve_q != SMAX)
                            starve_d = starve_q + 4'd1;
                        cmd_d = '{we: bus.d_we, addr: bus.d_addr,
                                  wdata: bus.d_wdata, wstrb: bus.d_wstrb};
                    end
                end
            end
            ISSUE: begin
                bus.m_req = 1'b1;
                if (bus.m_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (bus.m_rvalid) begin
                    state_d = IDLE;
                    if (grant_q)
                        bus.d_rvalid = 1'b1;
                    else
                        bus.if_rvalid = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data is only forwarded to the port whose response is valid.
    assign bus.if_rdata = bus.if_rvalid ? bus.m_rdata : 32'd0;
    assign bus.d_rdata  = bus.d_rvalid  ? bus.m_rdata : 32'd0;

    assign bus.m_we    = cmd_q.we;
    assign bus.m_addr  = cmd_q.addr;
    assign bus.m_wdata = cmd_q.wdata;
    assign bus.m_wstrb = cmd_q.wstrb;

    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            starve_q <= 4'd0;
            cmd_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
            cmd_q    <= cmd_d;
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the maximum consecutive data grants while fetch waits (range 1-15).
REQ-002 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; SHALL force reset state immediately, independent of clk.
REQ-004 if_req  in  1  fetch read request, held until if_ready.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_ready  out  1  fetch request accepted (one-cycle pulse).
REQ-007 if_rvalid  out  1  fetch read data valid (one-cycle pulse).
REQ-008 if_rdata  out  32  fetch read data.
REQ-009 d_req  in  1  data request, held until d_ready.
REQ-010 d_we  in  1  1=write, 0=read.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  write data.
REQ-013 d_wstrb  in  4  byte enables.
REQ-014 d_ready  out  1  data request accepted (one-cycle pulse).
REQ-015 d_rvalid  out  1  read data / write completion (one-cycle pulse).
REQ-016 d_rdata  out  32  data read data.
REQ-017 m_req  out  1  memory request.
REQ-018 m_we, m_addr[31:0], m_wdata[31:0], m_wstrb[3:0]  out  memory command fields.
REQ-019 m_ready  in  1  memory accepts m_req this cycle.
REQ-020 m_rvalid  in  1  memory response valid.
REQ-021 m_rdata  in  32  memory response data.
REQ-022 busy  out  1  state != IDLE; grant_id  out  1  registered owner (0=fetch, 1=data).

Function
REQ-023 States SHALL be IDLE, ISSUE, WAIT; only one outstanding memory transaction at a time.
REQ-024 IDLE: if either req high, winner SHALL be chosen, its ready pulsed combinationally that cycle, command fields registered, grant_id set, next state ISSUE.
REQ-025 Winner rule: data wins unless if_req high and starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-026 starve_cnt (4 bits) SHALL increment on a data grant with if_req high, saturate at STARVE_MAX, clear on any fetch grant or data grant with if_req low.
REQ-027 Fetch commands SHALL drive m_we=0, m_wstrb=4'b0000, m_wdata=0.
REQ-028 ISSUE: m_req=1 with registered fields held stable until m_ready=1, then next state WAIT; m_req=0 in all other states.
REQ-029 WAIT: on m_rvalid, owner's rvalid SHALL pulse same cycle with rdata=m_rdata; next state IDLE.
REQ-030 m_rvalid outside WAIT SHALL be ignored; both rvalid outputs SHALL stay 0.
REQ-031 Writes SHALL complete via d_rvalid; d_rdata content unspecified for writes.
REQ-032 if_ready/d_ready SHALL be 0 outside IDLE; requests arriving in ISSUE/WAIT wait for IDLE.
REQ-033 Latency: req in IDLE at cycle N, m_ready at N+1, m_rvalid at N+2 -> rvalid at N+2, next grant at N+3 (3-cycle minimum turnaround).
REQ-034 Non-owner rdata SHALL be 0.

Reset
REQ-035 On reset: state=IDLE, m_req=0, starve_cnt=0, grant_id=0, busy=0, command registers 0, all ready/rvalid outputs 0.
REQ-036 Reset mid-transaction SHALL abandon it; no rvalid SHALL be produced for it, even if m_rvalid arrives later.
REQ-037 First grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-038 Single fetch: if_req, if_addr=0x100, m_ready immediate, m_rvalid next cycle with 0x00000013 -> if_ready cycle N, m_req N+1, if_rvalid=1 and if_rdata=0x00000013 at N+2.
REQ-039 Simultaneous: if_req and d_req (write 0x2000, wdata 0xDEADBEEF, wstrb 0xF) both high -> data granted first, m_we=1, fetch granted next IDLE.
REQ-040 Starvation: d_req and if_req held continuously, STARVE_MAX=4 -> grant sequence D,D,D,D,F,D,D,D,D,F.
REQ-041 Backpressure: m_ready low 5 cycles -> m_req and m_addr/m_wdata stable all 5 cycles, busy=1, no ready pulses.
REQ-042 Reset asserted in WAIT, m_rvalid pulsed after release -> m_req drops immediately, no if_rvalid/d_rvalid, busy=0.
REQ-043 Spurious m_rvalid in IDLE -> both rvalid outputs remain 0, state unchanged.
